// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the text framestore scroll/clear engine.
// Holds the engine FSM encoding, command op codes and the debug view of the FSM.
package fb_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    FILL,
    DONE
  } fsm_state_t;

  typedef struct packed {
    fsm_state_t  state;
    logic        op;
    logic [15:0] idx;
  } dbg_t;

  localparam logic OP_SCROLL = 1'b0;
  localparam logic OP_CLEAR  = 1'b1;

  localparam logic [19:0] DEF_BASE_ADDR = 20'h80000;

  // Byte address of a 64-bit word; wraps modulo 2^20 like the bus itself.
  function automatic logic [19:0] word_addr(input logic [19:0] base, input logic [19:0] word);
    return base + (word << 3);
  endfunction

endpackage

// File: rtl/fb_port_arb.sv
// Single framestore port shared by CPU and engine; the CPU always wins.
// A read-ownership tag pipe steers returning read data to the CPU or the engine.
module fb_port_arb #(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_en,
  input  logic [7:0]  cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [63:0] cpu_wrdata,
  output logic [63:0] cpu_rddata,
  input  logic        eng_en,
  input  logic [7:0]  eng_we,
  input  logic [19:0] eng_addr,
  input  logic [63:0] eng_wrdata,
  output logic        o_eng_grant,
  output logic        o_eng_rd_ret,
  output logic        hid_en,
  output logic [7:0]  hid_we,
  output logic [19:0] hid_addr,
  output logic [63:0] hid_wrdata,
  input  logic [63:0] hid_rddata
);

  logic [RD_LAT-1:0] r_tag_v;
  logic [RD_LAT-1:0] r_tag_cpu;
  logic [63:0]       r_cpu_hold;
  logic              w_rd_issue;
  logic              w_cpu_ret;

  assign o_eng_grant = ~cpu_en;
  assign hid_en      = cpu_en ? 1'b1       : eng_en;
  assign hid_we      = cpu_en ? cpu_we     : eng_we;
  assign hid_addr    = cpu_en ? cpu_addr   : eng_addr;
  assign hid_wrdata  = cpu_en ? cpu_wrdata : eng_wrdata;

  assign w_rd_issue = hid_en && (hid_we == 8'h00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_v    <= '0;
      r_tag_cpu  <= '0;
      r_cpu_hold <= '0;
    end else begin
      r_tag_v[0]   <= w_rd_issue;
      r_tag_cpu[0] <= cpu_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_cpu[i] <= r_tag_cpu[i-1];
      end
      if (w_cpu_ret) r_cpu_hold <= hid_rddata;
    end
  end

  assign w_cpu_ret    = r_tag_v[RD_LAT-1] & r_tag_cpu[RD_LAT-1];
  assign o_eng_rd_ret = r_tag_v[RD_LAT-1] & ~r_tag_cpu[RD_LAT-1];

  // Show CPU data in its return cycle, then hold it across engine reads.
  assign cpu_rddata = w_cpu_ret ? hid_rddata : r_cpu_hold;

endmodule

// File: rtl/fb_text_scroll_ctrl.sv
// Scroll-up / clear engine for the text framestore.
// Scroll copies each word one row up (read, wait, write), then fills the last row.
module fb_text_scroll_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          ROW_WORDS = 32,
  parameter int          NUM_ROWS  = 48,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [63:0] fill_data,
  output logic        busy,
  output logic        done,
  input  logic        cpu_en,
  input  logic [7:0]  cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [63:0] cpu_wrdata,
  output logic [63:0] cpu_rddata,
  output logic        hid_en,
  output logic [7:0]  hid_we,
  output logic [19:0] hid_addr,
  output logic [63:0] hid_wrdata,
  input  logic [63:0] hid_rddata,
  output dbg_t        o_dbg
);

  localparam int TOTAL = NUM_ROWS * ROW_WORDS;
  localparam int IDX_W = $clog2(TOTAL) + 1;
  localparam logic [IDX_W-1:0] LAST_COPY = IDX_W'((NUM_ROWS - 1) * ROW_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_ALL  = IDX_W'(TOTAL - 1);

  fsm_state_t       r_state;
  fsm_state_t       w_state_nxt;
  logic             r_op;
  logic [63:0]      r_fill;
  logic [63:0]      r_copy_buf;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_accept;
  logic             w_copy_ld;
  logic             w_eng_en;
  logic [7:0]       w_eng_we;
  logic [19:0]      w_eng_addr;
  logic [63:0]      w_eng_wrdata;
  logic             w_eng_grant;
  logic             w_eng_rd_ret;
  logic [19:0]      w_rd_addr;
  logic [19:0]      w_wr_addr;

  // cmd_valid/cmd_ready: a command is taken in any cycle both are high; cmd_ready is
  // high only in IDLE/DONE, so requests while busy are dropped, never queued.
  assign cmd_ready = (r_state == IDLE) || (r_state == DONE);
  assign busy      = ~cmd_ready;
  assign done      = (r_state == DONE);
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_wr_addr = word_addr(BASE_ADDR, 20'(r_idx));
  assign w_rd_addr = word_addr(BASE_ADDR, 20'(r_idx) + 20'(ROW_WORDS));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_op       <= OP_SCROLL;
      r_fill     <= '0;
      r_copy_buf <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_fill <= fill_data;
      end
      if (w_copy_ld) r_copy_buf <= hid_rddata;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_copy_ld    = 1'b0;
    w_eng_en     = 1'b0;
    w_eng_we     = 8'h00;
    w_eng_addr   = '0;
    w_eng_wrdata = '0;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_idx_nxt   = '0;
          w_state_nxt = (cmd_op == OP_CLEAR) ? FILL : RD;
        end else if (r_state == DONE) begin
          w_state_nxt = IDLE;
        end
      end
      RD: begin
        w_eng_en   = 1'b1;
        w_eng_addr = w_rd_addr;
        if (w_eng_grant) w_state_nxt = WAIT;
      end
      // No port use here, so CPU traffic cannot make the engine miss its return.
      WAIT: begin
        if (w_eng_rd_ret) begin
          w_copy_ld   = 1'b1;
          w_state_nxt = WR;
        end
      end
      WR: begin
        w_eng_en     = 1'b1;
        w_eng_we     = 8'hFF;
        w_eng_addr   = w_wr_addr;
        w_eng_wrdata = r_copy_buf;
        if (w_eng_grant) begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = (r_idx == LAST_COPY) ? FILL : RD;
        end
      end
      FILL: begin
        w_eng_en     = 1'b1;
        w_eng_we     = 8'hFF;
        w_eng_addr   = w_wr_addr;
        w_eng_wrdata = r_fill;
        if (w_eng_grant) begin
          w_idx_nxt = r_idx + 1'b1;
          if (r_idx == LAST_ALL) w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_dbg = '{state: r_state, op: r_op, idx: 16'(r_idx)};

  fb_port_arb #(
    .RD_LAT(RD_LAT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_en      (cpu_en),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wrdata  (cpu_wrdata),
    .cpu_rddata  (cpu_rddata),
    .eng_en      (w_eng_en),
    .eng_we      (w_eng_we),
    .eng_addr    (w_eng_addr),
    .eng_wrdata  (w_eng_wrdata),
    .o_eng_grant (w_eng_grant),
    .o_eng_rd_ret(w_eng_rd_ret),
    .hid_en      (hid_en),
    .hid_we      (hid_we),
    .hid_addr    (hid_addr),
    .hid_wrdata  (hid_wrdata),
    .hid_rddata  (hid_rddata)
  );

endmodule

// File: tb/tb_fb_text_scroll_ctrl.sv
// Bench for fb_text_scroll_ctrl on a 4x2-word text area with a registered framestore model.
// Engine writes are checked in order against an expected queue filled when each command starts.
module tb_fb_text_scroll_ctrl;
  import fb_ctrl_pkg::*;

  localparam logic [19:0] BASE = 20'h80000;
  localparam int RW = 2;
  localparam int NR = 4;
  localparam int NW = NR * RW;
  localparam int MW = 16;
  localparam int LAT_SCROLL = (NR - 1) * RW * 3 + RW + 1;
  localparam int LAT_CLEAR  = NW + 1;

  logic        clk;
  logic        rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [63:0] fill_data;
  logic        busy;
  logic        done;
  logic        cpu_en;
  logic [7:0]  cpu_we;
  logic [19:0] cpu_addr;
  logic [63:0] cpu_wrdata;
  logic [63:0] cpu_rddata;
  logic        hid_en;
  logic [7:0]  hid_we;
  logic [19:0] hid_addr;
  logic [63:0] hid_wrdata;
  logic [63:0] hid_rddata = '0;
  dbg_t        dbg;

  int n_checks = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int eng_wr_cnt = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit sb_on = 0;

  logic [19:0] exp_addr_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] mem[MW];
  logic [63:0] model[NW];
  logic [63:0] rd_pend = '0;
  int          mon_w;
  logic [19:0] mon_ea;
  logic [63:0] mon_ed;

  fb_text_scroll_ctrl #(
    .BASE_ADDR(BASE), .ROW_WORDS(RW), .NUM_ROWS(NR), .RD_LAT(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .fill_data(fill_data),
    .busy(busy), .done(done),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
    .cpu_rddata(cpu_rddata),
    .hid_en(hid_en), .hid_we(hid_we), .hid_addr(hid_addr), .hid_wrdata(hid_wrdata),
    .hid_rddata(hid_rddata),
    .o_dbg(dbg)
  );

  // ---------------- clock / framestore model / monitor ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) hid_rddata <= rd_pend;

  function automatic int widx(input logic [19:0] a);
    logic [19:0] off;
    if (a < BASE) return -1;
    off = (a - BASE) >> 3;
    if (off >= 20'(MW)) return -1;
    return int'(off);
  endfunction

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (hid_en) begin
      mon_w = widx(hid_addr);
      if (hid_we != 8'h00) begin
        if (mon_w >= 0)
          for (int b = 0; b < 8; b++)
            if (hid_we[b]) mem[mon_w][8*b +: 8] = hid_wrdata[8*b +: 8];
        if (!cpu_en) begin
          eng_wr_cnt++;
          if (sb_on) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL sb_unexpected_write: got addr %h data %h, required no write", hid_addr, hid_wrdata);
            end else begin
              mon_ea = exp_addr_q.pop_front();
              mon_ed = exp_q.pop_front();
              if (hid_addr !== mon_ea || hid_wrdata !== mon_ed) begin
                n_fail++;
                $display("FAIL sb_write: got addr %h data %h, required addr %h data %h",
                         hid_addr, hid_wrdata, mon_ea, mon_ed);
              end
            end
          end
        end
      end else begin
        rd_pend = (mon_w >= 0) ? mem[mon_w] : 64'h0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic preload(input bit seq);
    logic [63:0] v;
    for (int i = 0; i < MW; i++) begin
      v = seq ? 64'(i) : {$urandom(), $urandom()};
      mem[i] = v;
      if (i < NW) model[i] = v;
    end
  endtask

  task automatic push_scroll(input logic [63:0] fill);
    for (int i = 0; i < NW - RW; i++) begin
      exp_addr_q.push_back(BASE + 20'(8 * i));
      exp_q.push_back(model[i + RW]);
      model[i] = model[i + RW];
    end
    for (int i = NW - RW; i < NW; i++) begin
      exp_addr_q.push_back(BASE + 20'(8 * i));
      exp_q.push_back(fill);
      model[i] = fill;
    end
  endtask

  task automatic push_clear(input logic [63:0] fill);
    for (int i = 0; i < NW; i++) begin
      exp_addr_q.push_back(BASE + 20'(8 * i));
      exp_q.push_back(fill);
      model[i] = fill;
    end
  endtask

  task automatic start_cmd(input logic op, input logic [63:0] fill, output logic rdy);
    cmd_valid = 1'b1;
    cmd_op    = op;
    fill_data = fill;
    acc_cyc   = cyc;
    #1 rdy = cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 400; k++) begin
      if (done) begin
        lat = cyc - acc_cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_engine(input fsm_state_t st, input int idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (dbg.state == st && int'(dbg.idx) == idx) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, busy, done, hid_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: got ready/busy/done/en %b, required 1000", {cmd_ready, busy, done, hid_en});
    end
    n_checks++;
    if (hid_we !== 8'h0 || hid_addr !== 20'h0 || hid_wrdata !== 64'h0 || cpu_rddata !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got we %h addr %h wd %h rd %h, required all zero",
               hid_we, hid_addr, hid_wrdata, cpu_rddata);
    end
    n_checks++;
    if (dbg.state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d, required IDLE", dbg.state);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clear;
    logic rdy;
    int lat, d0, w0;
    logic [63:0] fill;
    fill = 64'h0720_0720_0720_0720;
    preload(1'b0);
    sb_on = 1'b1;
    push_clear(fill);
    d0 = done_cnt;
    w0 = eng_wr_cnt;
    start_cmd(OP_CLEAR, fill, rdy);
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL clear_ready: got %b, required 1", rdy); end
    wait_done(lat);
    n_checks++;
    if (lat != LAT_CLEAR) begin n_fail++; $display("FAIL clear_latency: got %0d, required %0d", lat, LAT_CLEAR); end
    n_checks++;
    if (done_cnt != d0 + 1 || eng_wr_cnt != w0 + NW) begin
      n_fail++;
      $display("FAIL clear_counts: got done %0d writes %0d, required 1 and %0d", done_cnt - d0, eng_wr_cnt - w0, NW);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL clear_sb_left: got %0d, required 0", exp_q.size()); end
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== fill) begin n_fail++; $display("FAIL clear_mem[%0d]: got %h, required %h", i, mem[i], fill); end
    end
  endtask

  task automatic test_scroll;
    logic rdy;
    int lat, d0;
    logic [63:0] fill;
    fill = 64'hA5A5_0020_0020_5A5A;
    preload(1'b1);
    push_scroll(fill);
    d0 = done_cnt;
    start_cmd(OP_SCROLL, fill, rdy);
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL scroll_ready: got %b, required 1", rdy); end
    wait_done(lat);
    n_checks++;
    if (lat != LAT_SCROLL) begin n_fail++; $display("FAIL scroll_latency: got %0d, required %0d", lat, LAT_SCROLL); end
    n_checks++;
    if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL scroll_done: got %0d pulses, required 1", done_cnt - d0); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scroll_sb_left: got %0d, required 0", exp_q.size()); end
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== ((i < NW - RW) ? 64'(i + RW) : fill)) begin
        n_fail++;
        $display("FAIL scroll_mem[%0d]: got %h, required %h", i, mem[i], (i < NW - RW) ? 64'(i + RW) : fill);
      end
    end
  endtask

  task automatic test_cpu_hold;
    logic rdy;
    bit ok;
    int lat;
    logic [63:0] x, fill;
    x = {$urandom(), $urandom()};
    fill = {$urandom(), $urandom()};
    preload(1'b0);
    push_scroll(fill);
    start_cmd(OP_SCROLL, fill, rdy);
    wait_engine(WR, 2, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_reach_wr: got timeout, required WR idx 2"); end
    for (int j = 0; j < 5; j++) begin
      cpu_en     = 1'b1;
      cpu_we     = (j == 0) ? 8'hFF : 8'h00;
      cpu_addr   = BASE + 20'd80;
      cpu_wrdata = x;
      #1;
      n_checks++;
      if (hid_addr !== cpu_addr || hid_we !== cpu_we || hid_wrdata !== cpu_wrdata || hid_en !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_passthru: got addr %h we %h, required addr %h we %h", hid_addr, hid_we, cpu_addr, cpu_we);
      end
      @(posedge clk); #1;
      n_checks++;
      if (dbg.state !== WR || dbg.idx !== 16'd2) begin
        n_fail++;
        $display("FAIL hold_engine: got state %0d idx %0d, required WR idx 2", dbg.state, dbg.idx);
      end
    end
    cpu_en = 1'b0;
    cpu_we = 8'h00;
    #1;
    n_checks++;
    if (cpu_rddata !== x) begin n_fail++; $display("FAIL hold_cpu_rd: got %h, required %h", cpu_rddata, x); end
    wait_done(lat);
    n_checks++;
    if (lat != LAT_SCROLL + 5) begin n_fail++; $display("FAIL hold_latency: got %0d, required %0d", lat, LAT_SCROLL + 5); end
    n_checks++;
    if (mem[10] !== x) begin n_fail++; $display("FAIL hold_cpu_wr: got %h, required %h", mem[10], x); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_sb_left: got %0d, required 0", exp_q.size()); end
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== model[i]) begin n_fail++; $display("FAIL hold_mem[%0d]: got %h, required %h", i, mem[i], model[i]); end
    end
  endtask

  task automatic test_collision;
    logic rdy;
    bit ok;
    int lat;
    logic [63:0] y, fill;
    y = {$urandom(), $urandom()};
    fill = {$urandom(), $urandom()};
    preload(1'b0);
    mem[12] = y;
    push_scroll(fill);
    start_cmd(OP_SCROLL, fill, rdy);
    wait_engine(RD, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL coll_reach_rd: got timeout, required RD idx 1"); end
    @(posedge clk); #1;
    n_checks++;
    if (dbg.state !== WAIT) begin n_fail++; $display("FAIL coll_wait: got %0d, required WAIT", dbg.state); end
    cpu_en   = 1'b1;
    cpu_we   = 8'h00;
    cpu_addr = BASE + 20'd96;
    @(posedge clk); #1;
    cpu_en = 1'b0;
    #1;
    n_checks++;
    if (cpu_rddata !== y) begin n_fail++; $display("FAIL coll_cpu_rd: got %h, required %h", cpu_rddata, y); end
    n_checks++;
    if (dbg.state !== WR) begin n_fail++; $display("FAIL coll_eng_ret: got %0d, required WR", dbg.state); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (cpu_rddata !== y) begin n_fail++; $display("FAIL coll_cpu_hold: got %h, required %h", cpu_rddata, y); end
    wait_done(lat);
    n_checks++;
    if (lat != LAT_SCROLL) begin n_fail++; $display("FAIL coll_latency: got %0d, required %0d", lat, LAT_SCROLL); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL coll_sb_left: got %0d, required 0", exp_q.size()); end
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== model[i]) begin n_fail++; $display("FAIL coll_mem[%0d]: got %h, required %h", i, mem[i], model[i]); end
    end
  endtask

  task automatic test_reset_abort;
    logic rdy;
    bit ok;
    int lat, d0;
    logic [63:0] fill;
    fill = 64'h0720_0720_0720_0720;
    preload(1'b1);
    sb_on = 1'b0;
    start_cmd(OP_SCROLL, 64'h1111_2222_3333_4444, rdy);
    wait_engine(RD, 3, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_reach: got timeout, required RD idx 3"); end
    d0 = done_cnt;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({cmd_ready, busy, done, hid_en} !== 4'b1000 || hid_we !== 8'h0 || hid_addr !== 20'h0
        || hid_wrdata !== 64'h0 || cpu_rddata !== 64'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: got ready/busy/done/en %b addr %h rd %h, required 1000 and zeros",
               {cmd_ready, busy, done, hid_en}, hid_addr, cpu_rddata);
    end
    n_checks++;
    if (dbg.state !== IDLE || dbg.idx !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_state: got state %0d idx %0d, required IDLE idx 0", dbg.state, dbg.idx);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0); end
    sb_on = 1'b1;
    push_clear(fill);
    start_cmd(OP_CLEAR, fill, rdy);
    n_checks++;
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL abort_clear_ready: got %b, required 1", rdy); end
    wait_done(lat);
    n_checks++;
    if (lat != LAT_CLEAR || done_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL abort_clear_done: got lat %0d pulses %0d, required %0d and 1", lat, done_cnt - d0, LAT_CLEAR);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL abort_sb_left: got %0d, required 0", exp_q.size()); end
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== fill) begin n_fail++; $display("FAIL abort_mem[%0d]: got %h, required %h", i, mem[i], fill); end
    end
  endtask

  task automatic test_busy_ignore;
    logic rdy;
    int lat, d0;
    logic [63:0] fill;
    fill = {$urandom(), $urandom()};
    preload(1'b0);
    push_scroll(fill);
    d0 = done_cnt;
    start_cmd(OP_SCROLL, fill, rdy);
    for (int j = 0; j < 6; j++) begin
      cmd_valid = 1'b1;
      cmd_op    = OP_CLEAR;
      fill_data = ~fill;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_flags: got ready %b busy %b, required 0 1", cmd_ready, busy);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_done(lat);
    n_checks++;
    if (lat != LAT_SCROLL) begin n_fail++; $display("FAIL busy_latency: got %0d, required %0d", lat, LAT_SCROLL); end
    repeat (30) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_one_done: got %0d pulses busy %b, required 1 and 0", done_cnt - d0, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL busy_sb_left: got %0d, required 0", exp_q.size()); end
    for (int i = 0; i < NW; i++) begin
      n_checks++;
      if (mem[i] !== model[i]) begin n_fail++; $display("FAIL busy_mem[%0d]: got %h, required %h", i, mem[i], model[i]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_i      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    fill_data  = '0;
    cpu_en     = 1'b0;
    cpu_we     = '0;
    cpu_addr   = '0;
    cpu_wrdata = '0;
    for (int i = 0; i < MW; i++) mem[i] = '0;
    @(posedge clk); #1;
    test_reset();
    test_clear();
    test_scroll();
    test_cpu_hold();
    test_collision();
    test_reset_abort();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got no completion by 500000, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
